demux_1to8_32bits_reg: RTL and testbench



---
 rtl/demux_1to8_32bits_reg_pkg.sv | 23 ++
 rtl/demux_1to8_32bits_reg_decoder_3to8.sv | 24 ++
 rtl/demux_1to8_32bits_reg.sv | 165 ++++++++++++++++
 tb/tb_demux_1to8_32bits_reg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1to8_32bits_reg_pkg.sv
// ---------------------------------------------------------------------------
// demux_1to8_32bits_reg_pkg
// Shared constants for the registered 1-to-8 32-bit distributor.
//   - FSM state encoding (ST_IDLE / ST_BURST / ST_DONE)
//   - index width SEL_W, register count N_OUT, data width WIDTH
//   - next_idx(): wrap-around increment used by the burst walker
// ---------------------------------------------------------------------------
package demux_1to8_32bits_reg_pkg;

  localparam int SEL_W = 3;
  localparam int N_OUT = 8;
  localparam int WIDTH = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Index increment; the 3-bit width makes 7 -> 0 wrap naturally.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return idx + {{(SEL_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/demux_1to8_32bits_reg_decoder_3to8.sv
// ---------------------------------------------------------------------------
// decoder_3to8
// Maps a 3-bit index plus an enable to a one-hot 8-bit write enable.
// Ports:
//   i_idx    in   3  target register index
//   i_en     in   1  write enable; all outputs low when 0
//   o_onehot out  8  one-hot per-register write enable
// ---------------------------------------------------------------------------
module decoder_3to8
  import demux_1to8_32bits_reg_pkg::*;
(
  input  logic [SEL_W-1:0] i_idx,
  input  logic             i_en,
  output logic [N_OUT-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_1to8_32bits_reg.sv
// ---------------------------------------------------------------------------
// demux_1to8_32bits_reg
// Registered 1-to-8 32-bit distributor. Steers I into one of eight held
// output registers, either as a single write addressed by Select (IDLE) or
// as a burst walking the targets from Select with wrap-around.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepts single Write or Burst_Start (Burst_Start wins)
// ST_BURST | Ready high; each Valid cycle writes O[idx], idx advances
// ST_DONE  | one-cycle Done pulse, no writes, returns to IDLE
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   synchronous active-low reset
//   I            in   32  input data word
//   Select       in   3   single-write target / burst start index
//   Write        in   1   single-write strobe (IDLE only)
//   Clear        in   1   synchronous clear of outputs and Written, aborts burst
//   Burst_Start  in   1   start a burst (IDLE only)
//   Burst_Len    in   3   burst length minus one
//   Valid        in   1   burst data valid
//   Ready        out  1   high in BURST
//   Busy         out  1   high in BURST and DONE
//   Done         out  1   high in DONE
//   O0..O7       out  32  held output registers
//   Written      out  8   per-register written-since-clear flags
// ---------------------------------------------------------------------------
module demux_1to8_32bits_reg
  import demux_1to8_32bits_reg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] I,
  input  logic [SEL_W-1:0] Select,
  input  logic             Write,
  input  logic             Clear,
  input  logic             Burst_Start,
  input  logic [SEL_W-1:0] Burst_Len,
  input  logic             Valid,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7,
  output logic [N_OUT-1:0] Written
);

  logic [1:0]       r_state;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_data [N_OUT];
  logic [N_OUT-1:0] r_written;

  logic             w_in_idle;
  logic             w_in_burst;
  logic             w_single;
  logic             w_xfer;
  logic             w_wr_en;
  logic [SEL_W-1:0] w_wr_idx;
  logic [N_OUT-1:0] w_we;

  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_in_burst = (r_state == ST_BURST);

  // Burst_Start in the same cycle drops the single write.
  assign w_single = w_in_idle && Write && !Burst_Start;
  assign w_xfer   = w_in_burst && Valid;

  // Clear outranks every write, so it gates the decoder enable directly.
  assign w_wr_en  = (w_single || w_xfer) && !Clear;
  assign w_wr_idx = w_xfer ? r_idx : Select;

  decoder_3to8 u_dec (
    .i_idx    (w_wr_idx),
    .i_en     (w_wr_en),
    .o_onehot (w_we)
  );

  // Data registers with per-register enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N_OUT; k++) begin
        r_data[k] <= '0;
      end
      r_written <= '0;
    end else if (Clear) begin
      for (int k = 0; k < N_OUT; k++) begin
        r_data[k] <= '0;
      end
      r_written <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_we[k]) begin
          r_data[k] <= I;
        end
      end
      r_written <= r_written | w_we;
    end
  end

  // Burst sequencer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_remaining <= '0;
    end else if (Clear) begin
      // Abort without passing through DONE, so no Done pulse.
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Burst_Start) begin
            r_idx       <= Select;
            r_remaining <= Burst_Len;
            r_state     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (Valid) begin
            r_idx <= next_idx(r_idx);
            if (r_remaining == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_remaining <= r_remaining - {{(SEL_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode the state register only; no input reaches them
  // combinationally.
  assign Ready = w_in_burst;
  assign Busy  = w_in_burst || (r_state == ST_DONE);
  assign Done  = (r_state == ST_DONE);

  assign O0 = r_data[0];
  assign O1 = r_data[1];
  assign O2 = r_data[2];
  assign O3 = r_data[3];
  assign O4 = r_data[4];
  assign O5 = r_data[5];
  assign O6 = r_data[6];
  assign O7 = r_data[7];

  assign Written = r_written;

endmodule

// File: tb/tb_demux_1to8_32bits_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_1to8_32bits_reg
// Directed stimulus; each step pushes the hand-computed post-edge state into
// a scoreboard queue, and a negedge monitor pops and compares it.
// ---------------------------------------------------------------------------
module tb_demux_1to8_32bits_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] I;
  logic [2:0]  Select;
  logic        Write;
  logic        Clear;
  logic        Burst_Start;
  logic [2:0]  Burst_Len;
  logic        Valid;
  logic        Ready;
  logic        Busy;
  logic        Done;
  logic [31:0] O0, O1, O2, O3, O4, O5, O6, O7;
  logic [7:0]  Written;

  demux_1to8_32bits_reg dut (
    .clk         (clk),
    .reset       (reset),
    .I           (I),
    .Select      (Select),
    .Write       (Write),
    .Clear       (Clear),
    .Burst_Start (Burst_Start),
    .Burst_Len   (Burst_Len),
    .Valid       (Valid),
    .Ready       (Ready),
    .Busy        (Busy),
    .Done        (Done),
    .O0          (O0),
    .O1          (O1),
    .O2          (O2),
    .O3          (O3),
    .O4          (O4),
    .O5          (O5),
    .O6          (O6),
    .O7          (O7),
    .Written     (Written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                due;
    string             name;
    logic [7:0][31:0]  o;
    logic [7:0]        w;
    logic [2:0]        rbd;
  } exp_t;

  exp_t             q[$];
  logic [7:0][31:0] m_o;
  logic [7:0]       m_w;
  int               checks   = 0;
  int               failures = 0;

  // Expected state after the next rising edge, then advance one cycle.
  task automatic step(input string nm, input logic rdy, input logic bsy, input logic dn);
    exp_t e;
    e.due  = cyc + 1;
    e.name = nm;
    e.o    = m_o;
    e.w    = m_w;
    e.rbd  = {rdy, bsy, dn};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [7:0][31:0] act;
    exp_t e;
    act = {O7, O6, O5, O4, O3, O2, O1, O0};
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: sample missed (due cycle %0d, now %0d)", e.name, e.due, cyc);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      checks++;
      if (act !== e.o) begin
        failures++;
        $display("FAIL %s.O: got %h expected %h", e.name, act, e.o);
      end
      checks++;
      if (Written !== e.w) begin
        failures++;
        $display("FAIL %s.Written: got %h expected %h", e.name, Written, e.w);
      end
      checks++;
      if ({Ready, Busy, Done} !== e.rbd) begin
        failures++;
        $display("FAIL %s.RdyBsyDn: got %b expected %b", e.name, {Ready, Busy, Done}, e.rbd);
      end
    end
  end

  initial begin
    reset = 1'b0; I = 32'hFFFF_FFFF; Write = 1'b1; Select = 3'd0;
    Clear = 1'b0; Burst_Start = 1'b0; Burst_Len = 3'd0; Valid = 1'b0;
    m_o = '0; m_w = 8'h00;
    @(posedge clk); #1;

    // Reset held two cycles with a write pending.
    step("rst0", 0, 0, 0);
    step("rst1", 0, 0, 0);
    reset = 1'b1; Write = 1'b0;

    // Single write.
    Select = 3'd5; I = 32'hDEAD_BEEF; Write = 1'b1;
    m_o[5] = 32'hDEAD_BEEF; m_w = 8'h20;
    step("single", 0, 0, 0);
    Write = 1'b0; I = 32'h1234_5678;
    step("single_hold", 0, 0, 0);

    // Clear from IDLE so the wrap burst starts from an empty bank.
    Clear = 1'b1;
    m_o = '0; m_w = 8'h00;
    step("clr_idle", 0, 0, 0);
    Clear = 1'b0;

    // Wrap burst at 6, 4 words, stall of 2 between words 2 and 3.
    Burst_Start = 1'b1; Select = 3'd6; Burst_Len = 3'd3;
    step("wrap_start", 1, 1, 0);
    Burst_Start = 1'b0; Select = 3'd0;
    Valid = 1'b1; I = 32'd1; m_o[6] = 32'd1; m_w = 8'h40;
    step("wrap_w1", 1, 1, 0);
    I = 32'd2; m_o[7] = 32'd2; m_w = 8'hC0;
    step("wrap_w2", 1, 1, 0);
    Valid = 1'b0; I = 32'h99;
    step("wrap_stall1", 1, 1, 0);
    step("wrap_stall2", 1, 1, 0);
    Valid = 1'b1; I = 32'd3; m_o[0] = 32'd3; m_w = 8'hC1;
    step("wrap_w3", 1, 1, 0);
    I = 32'd4; m_o[1] = 32'd4; m_w = 8'hC3;
    step("wrap_w4", 0, 1, 1);
    Valid = 1'b0;
    step("wrap_after", 0, 0, 0);

    // Burst_Start and Write together: Write is dropped.
    Burst_Start = 1'b1; Write = 1'b1; Select = 3'd2; Burst_Len = 3'd0; I = 32'hAAAA_0002;
    step("prec_start", 1, 1, 0);
    Burst_Start = 1'b0; Select = 3'd4; I = 32'hBBBB_0004;
    step("prec_write_ign", 1, 1, 0);
    Write = 1'b0; Valid = 1'b1; I = 32'h55;
    m_o[2] = 32'h55; m_w = 8'hC7;
    step("prec_xfer", 0, 1, 1);
    Valid = 1'b0;
    step("prec_after", 0, 0, 0);

    // Clear after three transfers of an 8-word burst at 0.
    Burst_Start = 1'b1; Select = 3'd0; Burst_Len = 3'd7;
    step("clr_start", 1, 1, 0);
    Burst_Start = 1'b0; Valid = 1'b1;
    I = 32'hA0; m_o[0] = 32'hA0; m_w = 8'hC7;
    step("clr_w0", 1, 1, 0);
    I = 32'hA1; m_o[1] = 32'hA1;
    step("clr_w1", 1, 1, 0);
    I = 32'hA2; m_o[2] = 32'hA2;
    step("clr_w2", 1, 1, 0);
    Clear = 1'b1; I = 32'hEE;
    m_o = '0; m_w = 8'h00;
    step("clr_mid", 0, 0, 0);
    Clear = 1'b0; Valid = 1'b0; Write = 1'b1; Select = 3'd7; I = 32'h77;
    m_o[7] = 32'h77; m_w = 8'h80;
    step("clr_then_write", 0, 0, 0);
    Write = 1'b0;
    step("clr_no_done", 0, 0, 0);

    // Full 8-word burst at 3 writing 10..17.
    Burst_Start = 1'b1; Select = 3'd3; Burst_Len = 3'd7;
    step("full_start", 1, 1, 0);
    Burst_Start = 1'b0; Valid = 1'b1;
    I = 32'd10; m_o[3] = 32'd10; m_w = 8'h88; step("full_w0", 1, 1, 0);
    I = 32'd11; m_o[4] = 32'd11; m_w = 8'h98; step("full_w1", 1, 1, 0);
    I = 32'd12; m_o[5] = 32'd12; m_w = 8'hB8; step("full_w2", 1, 1, 0);
    I = 32'd13; m_o[6] = 32'd13; m_w = 8'hF8; step("full_w3", 1, 1, 0);
    I = 32'd14; m_o[7] = 32'd14; m_w = 8'hF8; step("full_w4", 1, 1, 0);
    I = 32'd15; m_o[0] = 32'd15; m_w = 8'hF9; step("full_w5", 1, 1, 0);
    I = 32'd16; m_o[1] = 32'd16; m_w = 8'hFB; step("full_w6", 1, 1, 0);
    I = 32'd17; m_o[2] = 32'd17; m_w = 8'hFF; step("full_w7", 0, 1, 1);
    // Burst_Start held through DONE is ignored there, taken in first IDLE.
    Valid = 1'b0; Burst_Start = 1'b1; Select = 3'd1; Burst_Len = 3'd0;
    step("b2b_done_exit", 0, 0, 0);
    step("b2b_start", 1, 1, 0);
    Burst_Start = 1'b0; Valid = 1'b1; I = 32'hCAFE;
    m_o[1] = 32'hCAFE;
    step("b2b_xfer", 0, 1, 1);
    Valid = 1'b0;
    step("b2b_after", 0, 0, 0);

    // Reset mid-burst clears partially written registers.
    Burst_Start = 1'b1; Select = 3'd0; Burst_Len = 3'd7;
    step("rstm_start", 1, 1, 0);
    Burst_Start = 1'b0; Valid = 1'b1; I = 32'h5A5A;
    m_o[0] = 32'h5A5A;
    step("rstm_w0", 1, 1, 0);
    reset = 1'b0; Clear = 1'b1;
    m_o = '0; m_w = 8'h00;
    step("rstm_reset", 0, 0, 0);
    reset = 1'b1; Clear = 1'b0; Valid = 1'b0;
    step("rstm_idle", 0, 0, 0);

    for (int n = 0; n < 20 && q.size() > 0; n++) begin
      @(posedge clk);
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected samples never compared, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
